// File: rtl/roic_align_pkg.sv
// ============================================================================
// roic_align_pkg : shared types and constants for the ROIC frame aligner
// Rev 1.0
// ============================================================================
`default_nettype none

package roic_align_pkg;

  localparam int                       ROIC_WORD_W        = 8;
  localparam logic [ROIC_WORD_W-1:0]   ROIC_FRAME_PATTERN = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } roic_align_state_e;

endpackage

`default_nettype wire

// File: rtl/roic_run_counter.sv
// ============================================================================
// roic_run_counter : saturating consecutive-event counter with clear and a
// terminal flag that fires on the event that completes the run.  Rev 1.0
// ============================================================================
`default_nettype none

module roic_run_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk_div,
  input  logic clk_reset_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int               CNT_W    = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_div or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag the LIMIT-th event itself so the owner can act on the same edge.
  assign hit_o = inc_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/roic_frame_aligner.sv
// ============================================================================
// roic_frame_aligner : bitslips the ISERDES lanes until the frame-clock word
// matches FRAME_PATTERN, then reports and supervises lock.  Rev 1.0
// ============================================================================
`default_nettype none

module roic_frame_aligner
  import roic_align_pkg::*;
#(
  parameter int                WORD_W        = ROIC_WORD_W,
  parameter logic [WORD_W-1:0] FRAME_PATTERN = ROIC_FRAME_PATTERN,
  parameter int                MATCH_CNT     = 16,
  parameter int                SLIP_SETTLE   = 3,
  parameter int                MAX_SLIPS     = 15,
  parameter int                LOSS_CNT      = 4
) (
  input  logic                               clk_div,
  input  logic                               clk_reset_n,
  input  logic                               align_start,
  input  logic [WORD_W-1:0]                  fclk_word,
  output logic                               bitslip,
  output logic                               aligned,
  output logic                               align_fail,
  output logic                               lock_lost,
  output logic [$clog2(MAX_SLIPS+1)-1:0]     slip_count
);

  localparam int                  SLIP_W      = $clog2(MAX_SLIPS + 1);
  localparam int                  SETTLE_W    = $clog2(SLIP_SETTLE + 1);
  localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(MAX_SLIPS);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SLIP_SETTLE);

  roic_align_state_e    state_q, state_d;
  logic [SLIP_W-1:0]    slip_cnt_q, slip_cnt_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 bitslip_q, bitslip_d;
  logic                 aligned_q, aligned_d;
  logic                 align_fail_q, align_fail_d;
  logic                 lock_lost_q, lock_lost_d;

  logic word_match;
  logic match_inc, match_clr, match_hit;
  logic miss_inc, miss_clr, miss_hit;

  assign word_match = (fclk_word == FRAME_PATTERN);

  // Each counter only runs while its owning state persists uninterrupted.
  assign match_inc = (state_q == ST_CHECK) && word_match;
  assign match_clr = align_start || (state_q != ST_CHECK) || !word_match;
  assign miss_inc  = (state_q == ST_LOCKED) && !word_match;
  assign miss_clr  = align_start || (state_q != ST_LOCKED) || word_match;

  roic_run_counter #(
    .LIMIT (MATCH_CNT)
  ) u_match_cnt (
    .clk_div     (clk_div),
    .clk_reset_n (clk_reset_n),
    .clr_i       (match_clr),
    .inc_i       (match_inc),
    .hit_o       (match_hit)
  );

  roic_run_counter #(
    .LIMIT (LOSS_CNT)
  ) u_miss_cnt (
    .clk_div     (clk_div),
    .clk_reset_n (clk_reset_n),
    .clr_i       (miss_clr),
    .inc_i       (miss_inc),
    .hit_o       (miss_hit)
  );

  always_comb begin
    state_d      = state_q;
    slip_cnt_d   = slip_cnt_q;
    settle_d     = settle_q;
    lock_lost_d  = 1'b0;

    if (align_start) begin
      state_d    = ST_CHECK;
      slip_cnt_d = '0;
      settle_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_CHECK: begin
          if (word_match) begin
            if (match_hit) begin
              state_d = ST_LOCKED;
            end
          end else if (slip_cnt_q == SLIP_MAX) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_SLIP;
          end
        end
        ST_SLIP: begin
          if (slip_cnt_q != SLIP_MAX) begin
            slip_cnt_d = slip_cnt_q + 1'b1;
          end
          settle_d = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          // Leave on the decrement that reaches zero: SLIP_SETTLE idle cycles.
          if (settle_q <= SETTLE_W'(1)) begin
            settle_d = '0;
            state_d  = ST_CHECK;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        ST_LOCKED: begin
          if (miss_hit) begin
            lock_lost_d = 1'b1;
            slip_cnt_d  = '0;
            state_d     = ST_CHECK;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    bitslip_d    = (state_d == ST_SLIP);
    // aligned follows LOCKED one cycle late on entry but drops on the exit edge.
    aligned_d    = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
    align_fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_div or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      state_q      <= ST_IDLE;
      slip_cnt_q   <= '0;
      settle_q     <= '0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      align_fail_q <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      slip_cnt_q   <= slip_cnt_d;
      settle_q     <= settle_d;
      bitslip_q    <= bitslip_d;
      aligned_q    <= aligned_d;
      align_fail_q <= align_fail_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign aligned    = aligned_q;
  assign align_fail = align_fail_q;
  assign lock_lost  = lock_lost_q;
  assign slip_count = slip_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_roic_frame_aligner.sv
// ============================================================================
// tb_roic_frame_aligner : scoreboard bench with an ISERDES rotate-on-slip model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_roic_frame_aligner;

  localparam int EV_SLIP  = 1;
  localparam int EV_ALIGN = 2;
  localparam int EV_FAIL  = 3;
  localparam int EV_LOST  = 4;

  typedef struct {
    int kind;
    int cyc;
    int slip;
    int algn;
  } ev_t;

  typedef struct {
    int tag;
    int cyc;
    int bs;
    int al;
    int af;
    int ll;
    int sc;
  } pr_t;

  logic       clk_div;
  logic       clk_reset_n;
  logic       align_start;
  logic [7:0] fclk_word;
  logic       bitslip;
  logic       aligned;
  logic       align_fail;
  logic       lock_lost;
  logic [3:0] slip_count;

  logic       ovr;
  logic [7:0] ovr_word;
  logic [2:0] base;
  logic [2:0] slips_seen = 3'd0;
  int         cyc = 0;
  logic       done = 1'b0;

  ev_t ev_q[$];
  pr_t pr_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  roic_frame_aligner dut (
    .clk_div     (clk_div),
    .clk_reset_n (clk_reset_n),
    .align_start (align_start),
    .fclk_word   (fclk_word),
    .bitslip     (bitslip),
    .aligned     (aligned),
    .align_fail  (align_fail),
    .lock_lost   (lock_lost),
    .slip_count  (slip_count)
  );

  initial begin
    clk_div = 1'b0;
    forever #5 clk_div = ~clk_div;
  end

  always @(posedge clk_div) cyc <= cyc + 1;

  // Every bitslip rotates the lane by one bit position.
  always @(posedge clk_div) if (bitslip) slips_seen <= slips_seen + 3'd1;

  function automatic logic [7:0] rotl(input logic [7:0] w, input logic [2:0] s);
    logic [15:0] t;
    t = {w, w} << s;
    return t[15:8];
  endfunction

  assign fclk_word = ovr ? ovr_word : rotl(8'hF0, 3'(base - slips_seen));

  function automatic void expect_ev(input int kind, input int c, input int slip, input int algn);
    ev_t e;
    e.kind = kind; e.cyc = c; e.slip = slip; e.algn = algn;
    ev_q.push_back(e);
  endfunction

  function automatic void probe(input int tag, input int c, input int bs, input int al,
                                input int af, input int ll, input int sc);
    pr_t p;
    p.tag = tag; p.cyc = c; p.bs = bs; p.al = al; p.af = af; p.ll = ll; p.sc = sc;
    pr_q.push_back(p);
  endfunction

  // Caller is at a negedge; returns the edge number that samples align_start.
  task automatic start(output int n);
    align_start = 1'b1;
    n = cyc + 1;
    @(negedge clk_div);
    align_start = 1'b0;
  endtask

  // Monitor: the only process that compares and steps the counters.
  task automatic check_ev(input int kind);
    ev_t e;
    n_cmp++;
    if (ev_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event kind=%0d at cyc=%0d slip_count=%0d (none expected)",
               kind, cyc, slip_count);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.slip != int'(slip_count) || e.algn != int'(aligned)) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d slip=%0d aligned=%0d, want kind=%0d cyc=%0d slip=%0d aligned=%0d",
                 kind, cyc, slip_count, aligned, e.kind, e.cyc, e.slip, e.algn);
      end
    end
  endtask

  initial begin : monitor
    pr_t p;
    logic prev_al;
    logic prev_af;
    prev_al = 1'b0;
    prev_af = 1'b0;
    forever begin
      @(negedge clk_div);
      while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
        p = pr_q.pop_front();
        n_cmp++;
        if (p.bs != int'(bitslip) || p.al != int'(aligned) || p.af != int'(align_fail) ||
            p.ll != int'(lock_lost) || p.sc != int'(slip_count)) begin
          n_fail++;
          $display("FAIL probe%0d cyc=%0d: got bs=%0d al=%0d af=%0d ll=%0d sc=%0d, want bs=%0d al=%0d af=%0d ll=%0d sc=%0d",
                   p.tag, cyc, bitslip, aligned, align_fail, lock_lost, slip_count,
                   p.bs, p.al, p.af, p.ll, p.sc);
        end
      end
      if (bitslip)                  check_ev(EV_SLIP);
      if (aligned && !prev_al)      check_ev(EV_ALIGN);
      if (align_fail && !prev_af)   check_ev(EV_FAIL);
      if (lock_lost)                check_ev(EV_LOST);
      prev_al = aligned;
      prev_af = align_fail;
      if (done) begin
        while (ev_q.size() > 0) begin
          ev_t e;
          e = ev_q.pop_front();
          n_cmp++;
          n_fail++;
          $display("FAIL missing_event kind=%0d: got nothing, want at cyc=%0d slip=%0d", e.kind, e.cyc, e.slip);
        end
        while (pr_q.size() > 0) begin
          p = pr_q.pop_front();
          n_cmp++;
          n_fail++;
          $display("FAIL missing_probe%0d: got nothing, want sample at cyc=%0d", p.tag, p.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before 200000 time units");
    $fatal(1);
  end

  initial begin : driver
    int n;
    int c;
    clk_reset_n = 1'b0;
    align_start = 1'b0;
    ovr         = 1'b0;
    ovr_word    = 8'h00;
    base        = 3'd0;

    @(negedge clk_div);
    probe(1, cyc + 1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_div);
    clk_reset_n = 1'b1;
    repeat (3) @(negedge clk_div);
    probe(2, cyc + 1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_div);

    // Already aligned: lock after MATCH_CNT matches, aligned one edge later.
    base = slips_seen;
    start(n);
    probe(3, n + 16, 0, 0, 0, 0, 0);
    expect_ev(EV_ALIGN, n + 17, 0, 1);
    repeat (20) @(negedge clk_div);

    // Three misses while locked are tolerated.
    c = cyc;
    probe(4, c + 3, 0, 1, 0, 0, 0);
    ovr = 1'b1;
    repeat (3) @(negedge clk_div);
    ovr = 1'b0;
    repeat (5) @(negedge clk_div);

    // Four misses drop lock and restart alignment from zero slips.
    c = cyc;
    expect_ev(EV_LOST, c + 4, 0, 0);
    probe(5, c + 5, 0, 0, 0, 0, 0);
    expect_ev(EV_ALIGN, c + 21, 0, 1);
    ovr = 1'b1;
    repeat (4) @(negedge clk_div);
    ovr = 1'b0;
    repeat (22) @(negedge clk_div);

    // Offset of three bits: three slips five cycles apart.
    base = 3'(slips_seen + 3'd3);
    start(n);
    expect_ev(EV_SLIP, n + 1, 0, 0);
    expect_ev(EV_SLIP, n + 6, 1, 0);
    expect_ev(EV_SLIP, n + 11, 2, 0);
    expect_ev(EV_ALIGN, n + 32, 3, 1);
    repeat (36) @(negedge clk_div);

    // Fifteen matches then a miss: slip, then a full fresh run of matches.
    base = slips_seen;
    start(n);
    expect_ev(EV_SLIP, n + 16, 0, 0);
    expect_ev(EV_ALIGN, n + 37, 1, 1);
    probe(6, n + 15, 0, 0, 0, 0, 0);
    repeat (15) @(negedge clk_div);
    base = 3'(base + 3'd1);
    repeat (30) @(negedge clk_div);

    // Pattern never appears: MAX_SLIPS slips then FAIL.
    ovr_word = 8'h00;
    ovr      = 1'b1;
    start(n);
    for (int i = 0; i < 15; i++) expect_ev(EV_SLIP, n + 1 + 5 * i, i, 0);
    expect_ev(EV_FAIL, n + 76, 15, 0);
    probe(7, n + 84, 0, 0, 1, 0, 15);
    repeat (86) @(negedge clk_div);

    // align_start clears FAIL and the slip count.
    ovr  = 1'b0;
    base = slips_seen;
    start(n);
    probe(8, n + 1, 0, 0, 0, 0, 0);
    expect_ev(EV_ALIGN, n + 17, 0, 1);
    repeat (22) @(negedge clk_div);

    // Reset landing mid-SETTLE clears outputs before the next clock edge.
    base = 3'(slips_seen + 3'd2);
    start(n);
    expect_ev(EV_SLIP, n + 1, 0, 0);
    probe(9, n + 3, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk_div);
    #1 clk_reset_n = 1'b0;
    repeat (3) @(negedge clk_div);
    clk_reset_n = 1'b1;
    repeat (20) @(negedge clk_div);
    probe(10, cyc + 1, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_div);
    done = 1'b1;
  end

endmodule

`default_nettype wire
